// File: rtl/hub75_line_capture.sv
// HUB75 receive-side line capture: oversamples panel pins, rebuilds each shifted row and
// replays it as a valid/ready stream. OE pulse measurement gated by HUB75_LINE_CAPTURE_OE_MEASURE_EN.
module hub75_line_capture #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OE_CNT_W    = 16
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                hub75_clk,
  input  logic                hub75_latch,
  input  logic                hub75_oe,
  input  logic [3:0]          hub75_row,
  input  logic [5:0]          hub75_rgb,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [5:0]          out_col,
  output logic [3:0]          out_row,
  output logic [5:0]          out_rgb,
  output logic                out_last,
  output logic                oe_valid,
  output logic [OE_CNT_W-1:0] oe_width,
  output logic [3:0]          oe_row,
  input  logic                clear_flags,
  output logic                overrun,
  output logic                overlength
);

  localparam int unsigned KW     = $clog2(WIDTH);
  localparam int unsigned CW     = $clog2(WIDTH + 1);
  localparam int unsigned SYNC_W = 12;

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SYNC_W-1:0] r_sync [SYNC_STAGES];
  logic [SYNC_W-1:0] w_sync;
  logic              r_clk_prev;
  logic              r_latch_prev;
  logic [5:0]        r_buf [2][WIDTH];
  logic              r_wsel;
  logic [CW-1:0]     r_cap_cnt;
  logic [CW-1:0]     r_line_len;
  logic [3:0]        r_line_row;
  logic [KW-1:0]     r_k;
  logic              r_overrun;
  logic              r_overlength;

  logic              w_clk_s;
  logic              w_latch_s;
  logic [3:0]        w_row_s;
  logic [5:0]        w_rgb_s;
  logic              w_clk_rise;
  logic              w_latch_rise;
  logic              w_pix_wr;
  logic [CW-1:0]     w_len_nxt;
  logic              w_accept;
  logic              w_hs;

  // Synchronizer chain for pixel clock, latch, row and RGB
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {hub75_clk, hub75_latch, hub75_row, hub75_rgb};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync       = r_sync[SYNC_STAGES-1];
  assign w_clk_s      = w_sync[11];
  assign w_latch_s    = w_sync[10];
  assign w_row_s      = w_sync[9:6];
  assign w_rgb_s      = w_sync[5:0];
  assign w_clk_rise   = w_clk_s & ~r_clk_prev;
  assign w_latch_rise = w_latch_s & ~r_latch_prev;
  assign w_pix_wr     = w_clk_rise && (r_cap_cnt < CW'(WIDTH));
  // A pixel edge coinciding with the latch edge belongs to the latched line
  assign w_len_nxt    = r_cap_cnt + CW'(w_pix_wr);
  assign w_accept     = w_latch_rise && (r_state == S_IDLE);
  assign w_hs         = out_valid && out_ready;

  // Capture buffer write; the drain side reads the other buffer, so it never changes under it
  always_ff @(posedge clk_in) begin
    if (w_pix_wr) r_buf[r_wsel][r_cap_cnt[KW-1:0]] <= w_rgb_s;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_clk_prev   <= 1'b0;
      r_latch_prev <= 1'b0;
      r_wsel       <= 1'b0;
      r_cap_cnt    <= '0;
      r_line_len   <= '0;
      r_line_row   <= '0;
      r_k          <= '0;
      r_overrun    <= 1'b0;
      r_overlength <= 1'b0;
    end else begin
      r_clk_prev   <= w_clk_s;
      r_latch_prev <= w_latch_s;
      if (w_latch_rise)  r_cap_cnt <= '0;
      else if (w_pix_wr) r_cap_cnt <= r_cap_cnt + CW'(1);
      if (w_accept) begin
        r_wsel     <= ~r_wsel;
        r_line_len <= w_len_nxt;
        r_line_row <= w_row_s;
        r_k        <= '0;
      end else if (w_hs) begin
        r_k <= r_k + KW'(1);
      end
      r_overrun    <= (w_latch_rise && (r_state != S_IDLE)) | (r_overrun & ~clear_flags);
      r_overlength <= (w_clk_rise && (r_cap_cnt == CW'(WIDTH))) | (r_overlength & ~clear_flags);
    end
  end

  assign overrun    = r_overrun;
  assign overlength = r_overlength;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (w_len_nxt != '0)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_hs && out_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stream words walk the drain buffer in shift order; columns count down like the driver
  always_comb begin
    out_valid = 1'b0;
    out_col   = '0;
    out_row   = '0;
    out_rgb   = '0;
    out_last  = 1'b0;
    if (r_state == S_DRAIN) begin
      out_valid = 1'b1;
      out_col   = 6'(KW'(WIDTH - 1) - r_k);
      out_row   = r_line_row;
      out_rgb   = r_buf[~r_wsel][r_k];
      out_last  = (CW'(r_k) == (r_line_len - CW'(1)));
    end
  end

`ifdef HUB75_LINE_CAPTURE_OE_MEASURE_EN
  logic [SYNC_STAGES:0] r_oe_s;
  logic [OE_CNT_W-1:0]  r_oe_cnt;
  logic                 r_oe_valid;
  logic [OE_CNT_W-1:0]  r_oe_width;
  logic [3:0]           r_oe_row;
  logic                 w_oe_lvl;
  logic                 w_oe_rise;
  logic                 w_oe_fall;

  assign w_oe_lvl  = r_oe_s[SYNC_STAGES-1];
  assign w_oe_rise = w_oe_lvl & ~r_oe_s[SYNC_STAGES];
  assign w_oe_fall = ~w_oe_lvl & r_oe_s[SYNC_STAGES];

  // Top bit of the chain is the previous synced level for edge detection
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_oe_s     <= '0;
      r_oe_cnt   <= '0;
      r_oe_valid <= 1'b0;
      r_oe_width <= '0;
      r_oe_row   <= '0;
    end else begin
      r_oe_s     <= {r_oe_s[SYNC_STAGES-1:0], hub75_oe};
      if (w_oe_rise)                       r_oe_cnt <= OE_CNT_W'(1);
      else if (w_oe_lvl && (r_oe_cnt != '1)) r_oe_cnt <= r_oe_cnt + OE_CNT_W'(1);
      r_oe_valid <= w_oe_fall;
      if (w_oe_fall) begin
        r_oe_width <= r_oe_cnt;
        r_oe_row   <= r_line_row;
      end
    end
  end

  assign oe_valid = r_oe_valid;
  assign oe_width = r_oe_width;
  assign oe_row   = r_oe_row;
`else
  logic w_unused_oe;
  assign w_unused_oe = hub75_oe;
  assign oe_valid    = 1'b0;
  assign oe_width    = '0;
  assign oe_row      = '0;
`endif

endmodule

// File: tb/tb_hub75_line_capture.sv
// Self-checking bench for hub75_line_capture: table of panel lines with a word scoreboard,
// plus hand sequences for overrun, coincident edges, OE measurement and reset mid-drain.
module tb_hub75_line_capture;

  logic        clk_in      = 1'b0;
  logic        reset       = 1'b1;
  logic        hub75_clk   = 1'b0;
  logic        hub75_latch = 1'b0;
  logic        hub75_oe    = 1'b0;
  logic [3:0]  hub75_row   = '0;
  logic [5:0]  hub75_rgb   = '0;
  logic        out_valid;
  logic        out_ready   = 1'b1;
  logic [5:0]  out_col;
  logic [3:0]  out_row;
  logic [5:0]  out_rgb;
  logic        out_last;
  logic        oe_valid;
  logic [15:0] oe_width;
  logic [3:0]  oe_row;
  logic        clear_flags = 1'b0;
  logic        overrun;
  logic        overlength;

  hub75_line_capture #(.WIDTH(64), .SYNC_STAGES(2), .OE_CNT_W(16)) dut (
    .clk_in(clk_in), .reset(reset), .hub75_clk(hub75_clk), .hub75_latch(hub75_latch),
    .hub75_oe(hub75_oe), .hub75_row(hub75_row), .hub75_rgb(hub75_rgb),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_row(out_row),
    .out_rgb(out_rgb), .out_last(out_last), .oe_valid(oe_valid), .oe_width(oe_width),
    .oe_row(oe_row), .clear_flags(clear_flags), .overrun(overrun), .overlength(overlength)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int npix;
    int row;
    int mul;
    int add;
    int rmode;
    int exp_words;
    int exp_ovl;
  } line_t;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int words_seen = 0;
  int valid_cycles = 0;
  int oe_pulses = 0;
  int last_oe_width = 0;
  int last_oe_row = 0;
  int rmode = 0;
  int rcyc = 0;
  bit hold = 1'b0;
  int held = 0;

  function automatic int pack_word(int col, int row, int rgb, int last);
    return (col << 11) | (row << 7) | (rgb << 1) | last;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h expected none", name, act);
  endtask

  // Scoreboard and stability monitor, sampled mid-cycle
  always @(negedge clk_in) begin
    int cur;
    if (reset) begin
      hold = 1'b0;
    end else begin
      cur = pack_word(int'(out_col), int'(out_row), int'(out_rgb), int'(out_last)) | (int'(out_valid) << 20);
      if (hold) check("hold_stable", cur, held);
      if (out_valid && out_ready) begin
        words_seen++;
        if (exp_q.size() == 0) fail("extra_word", cur);
        else check("word", cur & 32'hFFFFF, exp_q.pop_front());
      end
      hold = out_valid && !out_ready;
      held = cur;
      if (out_valid) valid_cycles++;
      if (oe_valid) begin
        oe_pulses++;
        last_oe_width = int'(oe_width);
        last_oe_row   = int'(oe_row);
      end
    end
  end

  // Sink readiness: 0 = always, 1 = one cycle in three, 2 = never
  always @(posedge clk_in) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rcyc % 3 == 0);
      default: out_ready = 1'b0;
    endcase
    rcyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic shift_pixel(input int rgb);
    hub75_rgb = 6'(rgb);
    tick(3);
    hub75_clk = 1'b1;
    tick(3);
    hub75_clk = 1'b0;
  endtask

  task automatic latch_pulse();
    tick(3);
    hub75_latch = 1'b1;
    tick(3);
    hub75_latch = 1'b0;
    tick(1);
  endtask

  task automatic shift_line(input int npix, input int row, input int mul, input int add);
    hub75_row = 4'(row);
    for (int i = 0; i < npix; i++) shift_pixel((i * mul + add) & 63);
  endtask

  task automatic enqueue_line(input int nw, input int row, input int mul, input int add);
    for (int k = 0; k < nw; k++)
      exp_q.push_back(pack_word(63 - k, row, (k * mul + add) & 63, (k == nw - 1) ? 1 : 0));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) fail("drain_timeout", exp_q.size());
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    tick(1);
  endtask

  task automatic oe_pulse(input int n);
    hub75_oe = 1'b1;
    tick(n);
    hub75_oe = 1'b0;
    tick(10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    line_t tbl[6];
    int w0, v0, p0, n;
    tbl[0] = '{64, 5, 1, 0, 0, 64, 0};
    tbl[1] = '{64, 10, 3, 7, 1, 64, 0};
    tbl[2] = '{1, 0, 1, 42, 0, 1, 0};
    tbl[3] = '{70, 15, 5, 1, 0, 64, 1};
    tbl[4] = '{0, 3, 1, 0, 0, 0, 0};
    tbl[5] = '{17, 9, 7, 3, 1, 17, 0};

    tick(3);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_col", int'(out_col), 0);
    check("rst_out_row", int'(out_row), 0);
    check("rst_out_rgb", int'(out_rgb), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_oe_valid", int'(oe_valid), 0);
    check("rst_oe_width", int'(oe_width), 0);
    check("rst_oe_row", int'(oe_row), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_overlength", int'(overlength), 0);
    reset = 1'b0;
    tick(3);

    for (int t = 0; t < 6; t++) begin
      rmode = tbl[t].rmode;
      w0 = words_seen;
      v0 = valid_cycles;
      enqueue_line(tbl[t].exp_words, tbl[t].row, tbl[t].mul, tbl[t].add);
      shift_line(tbl[t].npix, tbl[t].row, tbl[t].mul, tbl[t].add);
      latch_pulse();
      wait_drain();
      tick(10);
      check($sformatf("line%0d_words", t), words_seen - w0, tbl[t].exp_words);
      if (tbl[t].exp_words == 0) check($sformatf("line%0d_valid_cycles", t), valid_cycles - v0, 0);
      check($sformatf("line%0d_overlength", t), int'(overlength), tbl[t].exp_ovl);
      check($sformatf("line%0d_overrun", t), int'(overrun), 0);
      pulse_clear();
      check($sformatf("line%0d_ovl_cleared", t), int'(overlength), 0);
    end

    // OE measurement; last accepted line was row 9
    rmode = 0;
    p0 = oe_pulses;
    oe_pulse(736);
`ifdef HUB75_LINE_CAPTURE_OE_MEASURE_EN
    check("oe736_pulses", oe_pulses - p0, 1);
    check("oe736_width", last_oe_width, 736);
    check("oe736_row", last_oe_row, 9);
    check("oe736_width_held", int'(oe_width), 736);
    p0 = oe_pulses;
    oe_pulse(70000);
    check("oe_sat_pulses", oe_pulses - p0, 1);
    check("oe_sat_width", last_oe_width, 65535);
`else
    check("oe_off_pulses", oe_pulses - p0, 0);
    check("oe_off_width", int'(oe_width), 0);
    check("oe_off_row", int'(oe_row), 0);
`endif

    // Overrun: second latch while the first line is stalled
    rmode = 2;
    tick(2);
    w0 = words_seen;
    enqueue_line(8, 2, 1, 5);
    shift_line(8, 2, 1, 5);
    latch_pulse();
    tick(5);
    check("ovr_a_valid", int'(out_valid), 1);
    shift_line(5, 6, 1, 40);
    latch_pulse();
    tick(5);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_pending", exp_q.size(), 8);
    rmode = 0;
    wait_drain();
    tick(10);
    check("ovr_words", words_seen - w0, 8);
    check("ovr_sticky", int'(overrun), 1);
    pulse_clear();
    check("ovr_cleared", int'(overrun), 0);

    // Pixel and latch edges in the same cycle: pixel belongs to the line
    w0 = words_seen;
    exp_q.push_back(pack_word(63, 12, 11, 0));
    exp_q.push_back(pack_word(62, 12, 22, 0));
    exp_q.push_back(pack_word(61, 12, 33, 1));
    hub75_row = 4'd12;
    shift_pixel(11);
    shift_pixel(22);
    hub75_rgb = 6'd33;
    tick(3);
    hub75_clk   = 1'b1;
    hub75_latch = 1'b1;
    tick(3);
    hub75_clk   = 1'b0;
    hub75_latch = 1'b0;
    tick(1);
    wait_drain();
    tick(10);
    check("coincident_words", words_seen - w0, 3);

    // Reset at word 20 of a drain
    w0 = words_seen;
    enqueue_line(64, 4, 1, 0);
    shift_line(64, 4, 1, 0);
    latch_pulse();
    n = 0;
    while (words_seen - w0 < 20 && n < 500) begin
      tick(1);
      n++;
    end
    if (n >= 500) fail("mid_drain_timeout", words_seen - w0);
    reset = 1'b1;
    #1;
    check("reset_drops_valid", int'(out_valid), 0);
    exp_q.delete();
    tick(3);
    reset = 1'b0;
    tick(5);
    check("reset_no_resume", int'(out_valid), 0);
    w0 = words_seen;
    enqueue_line(64, 7, 1, 0);
    shift_line(64, 7, 1, 0);
    latch_pulse();
    wait_drain();
    tick(10);
    check("post_reset_words", words_seen - w0, 64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
